// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register word offsets,
// handshake state encoding, CAUSE field positions and TCON bit indices.
package irq_pkg;

  localparam logic [2:0] OFF_TH    = 3'd0;
  localparam logic [2:0] OFF_TL    = 3'd1;
  localparam logic [2:0] OFF_TCON  = 3'd2;
  localparam logic [2:0] OFF_PEND  = 3'd3;
  localparam logic [2:0] OFF_MASK  = 3'd4;
  localparam logic [2:0] OFF_CAUSE = 3'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam int CAUSE_VALID = 31;
  localparam int CAUSE_ID_W  = 3;

  localparam int TCON_RUN = 0;
  localparam int TCON_IE  = 1;
  localparam int TCON_OVF = 2;

endpackage

// File: rtl/irq_timer.sv
// Reload timer: TH/TL/TCON registers, overflow detect and timer irq pulse.
// Ports: clk, reset, wr/widx/wdata bus write, th/tl/tcon readback, tirq.
module irq_timer
  import irq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic [2:0]  widx,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        tirq
);

  logic run, ie, st, ovf;
  logic wr_th, wr_tl, wr_tcon;

  assign wr_th   = wr && (widx == OFF_TH);
  assign wr_tl   = wr && (widx == OFF_TL);
  assign wr_tcon = wr && (widx == OFF_TCON);

  // A TL write in the overflow cycle wins and suppresses the overflow.
  assign ovf  = run && (tl == 32'hFFFF_FFFF) && !wr_tl;
  assign tirq = ovf && ie;

  assign tcon[TCON_RUN] = run;
  assign tcon[TCON_IE]  = ie;
  assign tcon[TCON_OVF] = st;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th  <= '0;
      tl  <= '0;
      run <= 1'b0;
      ie  <= 1'b0;
      st  <= 1'b0;
    end else begin
      if (wr_th) th <= wdata;
      if (wr_tl) tl <= wdata;
      else if (ovf) tl <= th;
      else if (run) tl <= tl + 32'd1;
      if (wr_tcon) begin
        run <= wdata[TCON_RUN];
        ie  <= wdata[TCON_IE];
      end
      if (ovf) st <= 1'b1;
      else if (wr_tcon && wdata[TCON_OVF]) st <= 1'b0;
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller; optional timer under IRQ_TIMER_EN.
// Ports: bus (addr/wdata/MemWr/MemRd/rdata), src_irq, kernel_mode, irq_take, IRQ.
module irq_controller
  import irq_pkg::*;
#(
  parameter int          N_SRC     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             MemWr,
  input  logic             MemRd,
  output logic [31:0]      rdata,
  input  logic [N_SRC-1:0] src_irq,
  input  logic             kernel_mode,
  input  logic             irq_take,
  output logic             IRQ
);

  localparam int P = N_SRC + 1;

`ifdef IRQ_TIMER_EN
  localparam logic [P-1:0] IMPL = '1;
`else
  localparam logic [P-1:0] IMPL = {{N_SRC{1'b1}}, 1'b0};
`endif

  logic                  sel, wr, rd, eoi;
  logic [2:0]            widx;
  logic [31:0]           th, tl;
  logic [2:0]            tcon;
  logic                  tirq;
  logic [N_SRC-1:0]      src_q, src_q2;
  logic [P-1:0]          pend, mask, elig, setv, clrv;
  logic [CAUSE_ID_W-1:0] win, id, cause_id;
  logic                  cause_v, id_hit;
  state_t                state;

  assign sel  = (addr[31:5] == BASE_ADDR[31:5]);
  assign widx = addr[4:2];
  assign wr   = MemWr && sel;
  assign rd   = MemRd && sel;
  assign eoi  = wr && (widx == OFF_CAUSE);

`ifdef IRQ_TIMER_EN
  irq_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .wr    (wr),
    .widx  (widx),
    .wdata (wdata),
    .th    (th),
    .tl    (tl),
    .tcon  (tcon),
    .tirq  (tirq)
  );
`else
  assign th   = '0;
  assign tl   = '0;
  assign tcon = '0;
  assign tirq = 1'b0;
`endif

  // Edge seen on the registered copies so PEND sets one edge after sampling.
  assign setv = {src_q & ~src_q2, tirq};
  assign clrv = (wr && widx == OFF_PEND) ? wdata[P-1:0] : '0;
  assign elig = pend & mask;

  always_comb begin
    win = '0;
    for (int i = P - 1; i >= 0; i--)
      if (elig[i]) win = CAUSE_ID_W'(i);
  end

  always_comb begin
    id_hit = 1'b0;
    for (int i = 0; i < P; i++)
      if (elig[i] && CAUSE_ID_W'(i) == id) id_hit = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q  <= '0;
      src_q2 <= '0;
      pend   <= '0;
      mask   <= '0;
    end else begin
      src_q  <= src_irq;
      src_q2 <= src_q;
      pend   <= ((pend & ~clrv) | setv) & IMPL;
      if (wr && widx == OFF_MASK) mask <= wdata[P-1:0] & IMPL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      id       <= '0;
      cause_v  <= 1'b0;
      cause_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|elig) begin
            state <= REQ;
            id    <= win;
          end
        end
        REQ: begin
          if (irq_take) begin
            state    <= SERVICE;
            cause_v  <= 1'b1;
            cause_id <= id;
          end else if (!id_hit) begin
            state <= IDLE;
          end else begin
            id <= win;
          end
        end
        SERVICE: begin
          if (eoi) begin
            state   <= IDLE;
            cause_v <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign IRQ = (state == REQ) && !kernel_mode;

  always_comb begin
    rdata = '0;
    if (rd) begin
      case (widx)
        OFF_TH:    rdata = th;
        OFF_TL:    rdata = tl;
        OFF_TCON:  rdata[2:0] = tcon;
        OFF_PEND:  rdata[P-1:0] = pend;
        OFF_MASK:  rdata[P-1:0] = mask;
        OFF_CAUSE: begin
          rdata[CAUSE_VALID]       = cause_v;
          rdata[CAUSE_ID_W-1:0]    = cause_id;
        end
        default:   rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller.
// Covers reset, source handshake, priority, kernel gating, cancel, timer.
module tb_irq_controller;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        MemWr = 1'b0;
  logic        MemRd = 1'b0;
  logic [31:0] rdata;
  logic [3:0]  src_irq = '0;
  logic        kernel_mode = 1'b0;
  logic        irq_take = 1'b0;
  logic        IRQ;

  int checks = 0;
  int errors = 0;
  logic [31:0] v;

  irq_controller #(.N_SRC(4), .BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .reset       (reset),
    .addr        (addr),
    .wdata       (wdata),
    .MemWr       (MemWr),
    .MemRd       (MemRd),
    .rdata       (rdata),
    .src_irq     (src_irq),
    .kernel_mode (kernel_mode),
    .irq_take    (irq_take),
    .IRQ         (IRQ)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    addr  = BASE + off;
    wdata = d;
    MemWr = 1'b1;
    tick();
    MemWr = 1'b0;
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] d);
    addr  = BASE + off;
    MemRd = 1'b1;
    #1;
    d = rdata;
    MemRd = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("reset_irq", {31'b0, IRQ}, 32'h0);
    chk("reset_rdata_idle", rdata, 32'h0);
    rd(32'h0C, v); chk("reset_pend", v, 32'h0);
    rd(32'h10, v); chk("reset_mask", v, 32'h0);
    rd(32'h14, v); chk("reset_cause", v, 32'h0);
    rd(32'h08, v); chk("reset_tcon", v, 32'h0);

    // single source handshake
    wr(32'h10, 32'h2);
    src_irq = 4'b0001;
    tick();
    tick();
    rd(32'h0C, v); chk("src_pend", v, 32'h2);
    chk("src_irq_early", {31'b0, IRQ}, 32'h0);
    tick();
    chk("src_irq_n2", {31'b0, IRQ}, 32'h1);
    src_irq = 4'b0000;
    irq_take = 1'b1;
    tick();
    irq_take = 1'b0;
    chk("take_irq_low", {31'b0, IRQ}, 32'h0);
    rd(32'h14, v); chk("take_cause", v, 32'h8000_0001);
    wr(32'h0C, 32'h2);
    wr(32'h14, 32'h0);
    rd(32'h14, v); chk("eoi_valid", {31'b0, v[31]}, 32'h0);
    rd(32'h0C, v); chk("w1c_pend", v, 32'h0);
    tick();
    chk("eoi_idle_irq", {31'b0, IRQ}, 32'h0);

    // priority between two simultaneous sources
    wr(32'h10, 32'h1E);
    src_irq = 4'b1010;
    tick();
    tick();
    rd(32'h0C, v); chk("prio_pend", v, 32'h14);
    tick();
    chk("prio_irq", {31'b0, IRQ}, 32'h1);
    src_irq = 4'b0000;
    irq_take = 1'b1;
    tick();
    irq_take = 1'b0;
    rd(32'h14, v); chk("prio_cause_first", v, 32'h8000_0002);
    wr(32'h0C, 32'h4);
    wr(32'h14, 32'h0);
    tick();
    chk("prio_irq_second", {31'b0, IRQ}, 32'h1);
    irq_take = 1'b1;
    tick();
    irq_take = 1'b0;
    rd(32'h14, v); chk("prio_cause_second", v, 32'h8000_0004);
    wr(32'h0C, 32'h10);
    wr(32'h14, 32'h0);
    tick();

    // kernel-mode gating
    kernel_mode = 1'b1;
    src_irq = 4'b0001;
    tick();
    tick();
    tick();
    src_irq = 4'b0000;
    chk("kernel_gate", {31'b0, IRQ}, 32'h0);
    kernel_mode = 1'b0;
    #1;
    chk("kernel_release", {31'b0, IRQ}, 32'h1);

    // cancel while requesting
    wr(32'h0C, 32'h2);
    chk("cancel_still_req", {31'b0, IRQ}, 32'h1);
    tick();
    chk("cancel_irq_low", {31'b0, IRQ}, 32'h0);
    tick();
    chk("cancel_idle", {31'b0, IRQ}, 32'h0);
    rd(32'h14, v); chk("cancel_no_take", {31'b0, v[31]}, 32'h0);

`ifdef IRQ_TIMER_EN
    wr(32'h00, 32'hFFFF_FFFD);
    wr(32'h04, 32'hFFFF_FFFD);
    wr(32'h08, 32'h3);
    tick();
    tick();
    tick();
    rd(32'h04, v); chk("timer_tl_reload", v, 32'hFFFF_FFFD);
    rd(32'h08, v); chk("timer_tcon", v, 32'h7);
    rd(32'h0C, v); chk("timer_pend0", {31'b0, v[0]}, 32'h1);
    wr(32'h08, 32'h4);
    rd(32'h08, v); chk("timer_w1c_stop", v, 32'h0);
    wr(32'h0C, 32'h1);
`else
    wr(32'h08, 32'h3);
    rd(32'h08, v); chk("notimer_tcon", v, 32'h0);
    wr(32'h10, 32'h1F);
    rd(32'h10, v); chk("notimer_mask0", v, 32'h1E);
`endif

    // reset in the middle of a request
    wr(32'h10, 32'h2);
    src_irq = 4'b0001;
    tick();
    tick();
    tick();
    src_irq = 4'b0000;
    chk("midreq_irq", {31'b0, IRQ}, 32'h1);
    #1;
    reset = 1'b1;
    #1;
    chk("async_reset_irq", {31'b0, IRQ}, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    rd(32'h0C, v); chk("post_reset_pend", v, 32'h0);
    rd(32'h10, v); chk("post_reset_mask", v, 32'h0);
    rd(32'h14, v); chk("post_reset_cause", v, 32'h0);
    rd(32'h08, v); chk("post_reset_tcon", v, 32'h0);
    rd(32'h04, v); chk("post_reset_tl", v, 32'h0);
    chk("post_reset_irq", {31'b0, IRQ}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Memory-mapped interrupt controller for the single-cycle MIPS core, with an optional built-in reload timer. It edge-detects peripheral interrupt sources, holds them as pending, masks and prioritises them, and drives the level `IRQ` input of the control unit. It runs a request/service handshake so that exactly one interrupt is in service at a time. It sits on the data-memory bus beside the other peripherals and decodes its own address window.

## Interface
Parameters:
- `N_SRC`, 4: number of external interrupt sources (1..7).
- `BASE_ADDR`, 32'h4000_0000: base of the 32-byte register window; word-aligned.

Ports:
- `clk`  in  1: single system clock; all state on rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `addr`  in  32: byte address from the ALU result.
- `wdata`  in  32: store data.
- `MemWr`  in  1: store strobe.
- `MemRd`  in  1: load strobe.
- `rdata`  out  32: read data; 0 when not selected or `MemRd`=0.
- `src_irq`  in  N_SRC: peripheral requests, rising-edge sensitive.
- `kernel_mode`  in  1: PC[31]; 1 = CPU in handler, interrupts blocked.
- `irq_take`  in  1: CPU commits interrupt entry this cycle (PCSrc = 3'b100 taken).
- `IRQ`  out  1: interrupt request to the control unit.

## Operation
- Register map, word offsets from `BASE_ADDR`:
  - 0x00 TH: timer reload value, R/W.
  - 0x04 TL: timer count, R/W.
  - 0x08 TCON: bit0 run, bit1 timer irq enable, bit2 overflow status (W1C); other bits read 0.
  - 0x0C PEND: bit0 timer, bits[N_SRC:1] sources; write-1-to-clear.
  - 0x10 MASK: same layout; 1 = enabled; reset 0.
  - 0x14 CAUSE: bit31 valid, bits[2:0] in-service id; any write = end-of-interrupt (EOI).
  - Other offsets read 0, writes ignored.
- Source edge: a 0→1 on `src_irq[i]` (registered previous value) sets PEND[i+1].
- Timer:
  - While run=1, TL increments by 1 each cycle.
  - At TL=32'hFFFF_FFFF, the next edge loads TL←TH and sets TCON.status.
  - Also sets PEND[0] if TCON bit1=1.
- Eligible = PEND & MASK. Winner = lowest set index (timer highest priority).
- State machine (3 states):
  - IDLE: if eligible≠0 → REQ, latching winner id.
  - REQ: `IRQ` = !kernel_mode.
    - `irq_take`=1 → SERVICE; CAUSE = {1, id}.
    - If the latched PEND bit is cleared before take → IDLE.
  - SERVICE: `IRQ`=0; new pendings accumulate.
    - CAUSE write (EOI) → IDLE; CAUSE.valid←0.
- Priority is re-evaluated in REQ each cycle; a higher-priority arrival replaces the latched id before take.
- Simultaneous events:
  - Source edge and W1C on the same bit: set wins.
  - Timer overflow and a TL write in the same cycle: write wins, no status set.
  - `irq_take` outside REQ: ignored.

## Timing
- Reset values: `IRQ`=0, `rdata`=0, TH=TL=TCON=PEND=MASK=0, CAUSE=0, state IDLE.
- `rdata` is combinational from `addr`/`MemRd`, for the single-cycle load path.
- Writes take effect at the clock edge with `MemWr`=1.
- Latency:
  - `src_irq` edge at edge N sets PEND at edge N+1.
  - With the bit enabled, REQ is entered at N+2.
  - `IRQ` is high in cycle N+2 if kernel_mode=0.
- `IRQ` is registered-state-derived and is gated only combinationally by `kernel_mode`.
- Reset mid-handshake returns to IDLE immediately; `IRQ` drops asynchronously.

## Configuration
- `IRQ_TIMER_EN` defined:
  - Timer, TH/TL/TCON and PEND[0] are implemented.
- Undefined:
  - No timer logic.
  - Offsets 0x00–0x08 read 0, writes ignored.
  - PEND[0] and MASK[0] are tied 0.

## Structure
- Shared package `irq_pkg`:
  - Register offsets.
  - State enum (IDLE/REQ/SERVICE).
  - CAUSE field positions.
  - TCON bit indices.
- One sub-module, `irq_timer`: TH/TL/TCON registers and overflow pulse, instantiated under `IRQ_TIMER_EN`.

## Test plan
- Reset: assert `reset` mid-REQ → `IRQ`=0 immediately; all registers read 0 after release.
- Source: MASK=0x2, pulse `src_irq[0]` → `IRQ`=1 two cycles later.
  - `irq_take` → `IRQ`=0, CAUSE reads 32'h8000_0001.
  - EOI write → CAUSE valid=0.
- Priority: MASK=0x1E, edges on src 1 and src 3 in the same cycle → CAUSE id=2.
  - After EOI and W1C of bit2 → second request, id=4.
- Kernel gating: kernel_mode=1 with an eligible request → `IRQ`=0.
  - Drop kernel_mode → `IRQ`=1 the same cycle.
- Timer (with `IRQ_TIMER_EN`): TH=TL=32'hFFFF_FFFD, TCON=3 → after 3 cycles TL=TH, TCON reads 7, PEND[0]=1.
  - Without the macro: TCON reads 0.
- Cancel: W1C the latched bit while in REQ → `IRQ` falls next cycle; state returns to IDLE with no take.
